// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg
//   Shared definitions for the PWM burst sequencer: default widths, the
//   ack timeout, and the sequencer state encoding. The top level, the gap
//   timer and the testbench all import this package.
package pwm_seq_pkg;

   localparam int RAM_WIDTH_DEF   = 32;  // die / pulse period field width
   localparam int CNT_W_DEF       = 16;  // pulse count, gap and pulses_sent width
   localparam int ACK_TIMEOUT_DEF = 8;   // cycles allowed for pulse_valid to rise

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_FIRE     = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_WAIT_END = 3'd4,
      ST_GAP      = 3'd5,
      ST_DONE     = 3'd6
   } state_e;

endpackage

// File: rtl/pwm_gap_timer.sv
// pwm_gap_timer
//   Loadable down-counter with a zero flag. The sequencer shares one
//   instance between the inter-pulse gap countdown and the ack timeout,
//   since the two are never active at the same time.
//
// Ports
//   clk_i       : clock
//   rst_i       : synchronous active-high reset (counter to 0)
//   load_i      : load load_val_i (wins over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement by one; the counter holds at zero
//   zero_o      : counter is zero
module pwm_gap_timer
   import pwm_seq_pkg::*;
#(
   parameter int W = CNT_W_DEF
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pwm_burst_sequencer.sv
// pwm_burst_sequencer
//   Sequences bursts of pulses on one half_pwm_die channel pair. A start
//   request latches the burst configuration into shadow registers that
//   drive the PWM core, then the FSM issues one-cycle enable strobes,
//   waits for the core's pulse_valid to rise and fall for each pulse,
//   and inserts programmable idle gaps between pulses. Idle, abort and
//   ack-timeout all force the core to its default level.
//
//   Every output is a register. Status outputs (pwm_en, pwm_dis, busy,
//   done) are decoded from the state register, so they trail the state
//   by one cycle.
//
// Ports
//   io_clk, io_rst        : clock, synchronous active-high reset
//   start, abort          : burst request (ignored while busy), level abort
//   cfg_*                 : burst configuration, latched on accepted start
//   pulse_valid           : from the PWM core, high while a pulse runs
//   pwm_en                : one-cycle fire strobe to the core
//   pwm_dis               : force the core to its default level
//   die_period,
//   pulse_period,
//   io_defaultLevel       : shadow registers driving the core
//   busy, done, fault     : burst in progress, end strobe, sticky timeout
//   pulses_sent           : pulses completed in the current/last burst
module pwm_burst_sequencer
   import pwm_seq_pkg::*;
#(
   parameter int _RAM_WIDTH  = RAM_WIDTH_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic                  io_clk,
   input  logic                  io_rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [_RAM_WIDTH-1:0] cfg_die_period,
   input  logic [_RAM_WIDTH-1:0] cfg_pulse_period,
   input  logic [CNT_W-1:0]      cfg_pulse_count,
   input  logic [CNT_W-1:0]      cfg_gap,
   input  logic                  cfg_default_level,
   input  logic                  pulse_valid,
   output logic                  pwm_en,
   output logic                  pwm_dis,
   output logic [_RAM_WIDTH-1:0] die_period,
   output logic [_RAM_WIDTH-1:0] pulse_period,
   output logic                  io_defaultLevel,
   output logic                  busy,
   output logic                  done,
   output logic                  fault,
   output logic [CNT_W-1:0]      pulses_sent
);

   // The timer is checked for zero one edge after it reaches zero, so
   // loading ACK_TIMEOUT-1 gives exactly ACK_TIMEOUT cycles in WAIT_ACK.
   localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_TIMEOUT - 1);

   state_e                  state_q, state_d;
   logic [_RAM_WIDTH-1:0]   die_period_q, pulse_period_q;
   logic                    default_level_q;
   logic [CNT_W-1:0]        remaining_q, gap_q, pulses_sent_q;
   logic                    pwm_en_q, pwm_dis_q, busy_q, done_q, fault_q;
   logic                    timeout_q;     // this burst ended on ack timeout
   logic                    zero_start_q;  // zero-count start seen last edge

   logic                    accept, zero_req, abort_hit;
   logic                    tmr_load, tmr_zero;
   logic [CNT_W-1:0]        tmr_val;
   logic                    pulse_done, timed_out;

   // Start with abort also high is dropped entirely.
   assign accept    = (state_q == ST_IDLE) && start && !abort && (cfg_pulse_count != '0);
   assign zero_req  = (state_q == ST_IDLE) && start && !abort && (cfg_pulse_count == '0);
   assign abort_hit = abort && (state_q != ST_IDLE) && (state_q != ST_DONE);

   always_comb begin
      state_d    = state_q;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      pulse_done = 1'b0;
      timed_out  = 1'b0;
      if (abort_hit) begin
         state_d = ST_DONE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) state_d = ST_LOAD;
            end
            ST_LOAD: state_d = ST_FIRE;
            ST_FIRE: begin
               state_d  = ST_WAIT_ACK;
               tmr_load = 1'b1;
               tmr_val  = ACK_LOAD;
            end
            ST_WAIT_ACK: begin
               // A late ack on the final cycle still counts.
               if (pulse_valid) begin
                  state_d = ST_WAIT_END;
               end else if (tmr_zero) begin
                  state_d   = ST_DONE;
                  timed_out = 1'b1;
               end
            end
            ST_WAIT_END: begin
               if (!pulse_valid) begin
                  pulse_done = 1'b1;
                  if (remaining_q == '0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d  = ST_GAP;
                     tmr_load = 1'b1;
                     tmr_val  = gap_q;
                  end
               end
            end
            ST_GAP: begin
               if (tmr_zero) state_d = ST_FIRE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   pwm_gap_timer #(.W(CNT_W)) u_timer (
      .clk_i      (io_clk),
      .rst_i      (io_rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      ((state_q == ST_GAP) || (state_q == ST_WAIT_ACK)),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge io_clk) begin
      if (io_rst) begin
         state_q         <= ST_IDLE;
         die_period_q    <= '0;
         pulse_period_q  <= '0;
         default_level_q <= 1'b0;
         remaining_q     <= '0;
         gap_q           <= '0;
         pulses_sent_q   <= '0;
         pwm_en_q        <= 1'b0;
         pwm_dis_q       <= 1'b1;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         fault_q         <= 1'b0;
         timeout_q       <= 1'b0;
         zero_start_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         // An abort sampled in FIRE suppresses the strobe.
         pwm_en_q     <= (state_q == ST_FIRE) && !abort;
         pwm_dis_q    <= (state_q == ST_IDLE) || (state_q == ST_DONE);
         busy_q       <= (state_q != ST_IDLE);
         done_q       <= (state_q == ST_DONE) || zero_start_q;
         zero_start_q <= zero_req;

         if (accept) begin
            die_period_q    <= cfg_die_period;
            pulse_period_q  <= cfg_pulse_period;
            default_level_q <= cfg_default_level;
            remaining_q     <= cfg_pulse_count;
            gap_q           <= cfg_gap;
            pulses_sent_q   <= '0;
            fault_q         <= 1'b0;
            timeout_q       <= 1'b0;
         end

         if ((state_q == ST_FIRE) && !abort && (remaining_q != '0)) begin
            remaining_q <= remaining_q - CNT_W'(1);
         end

         if (pulse_done) begin
            pulses_sent_q <= pulses_sent_q + CNT_W'(1);
         end

         if (timed_out) begin
            timeout_q <= 1'b1;
         end

         // fault is published together with the done strobe.
         if (state_q == ST_DONE) begin
            fault_q   <= fault_q | timeout_q;
            timeout_q <= 1'b0;
         end
      end
   end

   assign pwm_en          = pwm_en_q;
   assign pwm_dis         = pwm_dis_q;
   assign die_period      = die_period_q;
   assign pulse_period    = pulse_period_q;
   assign io_defaultLevel = default_level_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign fault           = fault_q;
   assign pulses_sent     = pulses_sent_q;

endmodule
